// File: rtl/hazard_detection_unit_if.sv
// Issue-side hazard bus: ID/EX/MEM register indices and load flags in, pipeline-register controls out.
// The slave side is the hazard unit; the master side is the pipeline datapath.
interface hazard_detection_unit_if;
    logic [4:0] IF_IDregisterRs;
    logic [4:0] IF_IDregisterRt;
    logic       IF_IDbranch;
    logic [4:0] ID_EXregisterRt;
    logic       ID_EXmemRead;
    logic [4:0] EX_MEMregisterRd;
    logic       EX_MEMmemRead;
    logic       dmem_ready;
    logic       branch_taken;

    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       pipe_hold;

    modport slave (
        input  IF_IDregisterRs, IF_IDregisterRt, IF_IDbranch,
        input  ID_EXregisterRt, ID_EXmemRead,
        input  EX_MEMregisterRd, EX_MEMmemRead,
        input  dmem_ready, branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold
    );

    modport master (
        output IF_IDregisterRs, IF_IDregisterRt, IF_IDbranch,
        output ID_EXregisterRt, ID_EXmemRead,
        output EX_MEMregisterRd, EX_MEMmemRead,
        output dmem_ready, branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold
    );
endinterface

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard unit: load-use / load-to-branch stalls, data-memory wait holds, taken-branch flushes.
// Optional stall-cycle performance counter enabled by defining HDU_PERF_CNT_EN.
module hazard_detection_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     arst,
    hazard_detection_unit_if.slave   bus
`ifdef HDU_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]     stall_cycles
`endif
);

    typedef enum logic [1:0] {RUN, BR_STALL, MEM_WAIT} state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_hold;
    } ctl_t;

    localparam ctl_t CTL_ADV   = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                   id_ex_bubble: 1'b0, pipe_hold: 1'b0};
    localparam ctl_t CTL_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                   id_ex_bubble: 1'b0, pipe_hold: 1'b0};
    localparam ctl_t CTL_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                   id_ex_bubble: 1'b1, pipe_hold: 1'b0};
    localparam ctl_t CTL_HOLD  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                   id_ex_bubble: 1'b0, pipe_hold: 1'b1};

    state_t state, state_nxt;
    ctl_t   ctl, run_ctl;
    state_t run_nxt;
    logic   lu, bl, mw;

    // Register 0 is hard-wired, so it never creates a dependency.
    assign lu = bus.ID_EXmemRead && (bus.ID_EXregisterRt != 5'd0) &&
                ((bus.ID_EXregisterRt == bus.IF_IDregisterRs) ||
                 (bus.ID_EXregisterRt == bus.IF_IDregisterRt));
    assign bl = bus.IF_IDbranch && bus.EX_MEMmemRead && (bus.EX_MEMregisterRd != 5'd0) &&
                ((bus.EX_MEMregisterRd == bus.IF_IDregisterRs) ||
                 (bus.EX_MEMregisterRd == bus.IF_IDregisterRt));
    assign mw = bus.EX_MEMmemRead && !bus.dmem_ready;

    // Decision of a free-running pipeline; reused when a memory wait releases.
    always_comb begin
        run_ctl = CTL_ADV;
        run_nxt = RUN;
        if (mw) begin
            run_ctl = CTL_HOLD;
            run_nxt = MEM_WAIT;
        end else if (lu || bl) begin
            run_ctl = CTL_STALL;
            // A branch behind a load needs a second cycle once the load reaches MEM.
            run_nxt = (lu && bus.IF_IDbranch) ? BR_STALL : RUN;
        end else if (bus.branch_taken) begin
            run_ctl = CTL_FLUSH;
        end
    end

    always_comb begin
        ctl       = CTL_ADV;
        state_nxt = RUN;
        unique case (state)
            RUN: begin
                ctl       = run_ctl;
                state_nxt = run_nxt;
            end
            BR_STALL: begin
                ctl       = CTL_STALL;
                state_nxt = RUN;
                if (mw) begin
                    ctl.pipe_hold = 1'b1;
                    state_nxt     = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    ctl       = run_ctl;
                    state_nxt = RUN;
                end else begin
                    ctl       = CTL_HOLD;
                    state_nxt = MEM_WAIT;
                end
            end
            default: begin
                ctl       = CTL_ADV;
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= RUN;
        else      state <= state_nxt;
    end

    assign bus.pc_write     = ctl.pc_write;
    assign bus.if_id_write  = ctl.if_id_write;
    assign bus.if_id_flush  = ctl.if_id_flush;
    assign bus.id_ex_bubble = ctl.id_ex_bubble;
    assign bus.pipe_hold    = ctl.pipe_hold;

`ifdef HDU_PERF_CNT_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst)              stall_cycles <= '0;
        else if (!ctl.pc_write) stall_cycles <= stall_cycles + 1'b1;
    end
`endif

    // A PC advance must always be accompanied by IF/ID loading something.
    a_pc_ifid: assert property (@(posedge clk) disable iff (arst)
        bus.pc_write |-> (bus.if_id_write || bus.if_id_flush));

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit; expected control vectors are hand-computed.
module tb_hazard_detection_unit;
    logic clk;
    logic arst;
    int   n_vec;
    int   n_err;

    hazard_detection_unit_if hif();

`ifdef HDU_PERF_CNT_EN
    logic [3:0] stall_cycles;
`endif

    hazard_detection_unit #(.CNT_WIDTH(4)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (hif)
`ifdef HDU_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}
    localparam logic [4:0] ADV   = 5'b11000;
    localparam logic [4:0] FLUSH = 5'b11100;
    localparam logic [4:0] STALL = 5'b00010;
    localparam logic [4:0] HOLD  = 5'b00001;
    localparam logic [4:0] BHOLD = 5'b00011;

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.id_ex_bubble, hif.pipe_hold};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clr();
        hif.IF_IDregisterRs  = 5'd0;
        hif.IF_IDregisterRt  = 5'd0;
        hif.IF_IDbranch      = 1'b0;
        hif.ID_EXregisterRt  = 5'd0;
        hif.ID_EXmemRead     = 1'b0;
        hif.EX_MEMregisterRd = 5'd0;
        hif.EX_MEMmemRead    = 1'b0;
        hif.dmem_ready       = 1'b1;
        hif.branch_taken     = 1'b0;
    endtask

    // Next cycle: inputs are applied just after the falling edge, outputs sampled 1 ns later.
    task automatic nxt();
        @(negedge clk);
        clr();
    endtask

    task automatic set_lu(input logic [4:0] r);
        hif.ID_EXmemRead    = 1'b1;
        hif.ID_EXregisterRt = r;
        hif.IF_IDregisterRs = r;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        arst  = 1'b1;
        clr();
        #1 chk("reset_run", ADV);
        nxt(); #1 chk("reset_held", ADV);
        arst = 1'b0;
`ifdef HDU_PERF_CNT_EN
        n_vec++;
        assert (stall_cycles === 4'd0) else begin
            n_err++;
            $error("FAIL cnt_reset observed=%0d expected=0", stall_cycles);
        end
`endif
        nxt(); #1 chk("idle", ADV);

        // Load-use on Rs and on Rt, one stall each
        nxt(); set_lu(5'd8); #1 chk("lu_rs", STALL);
        nxt(); #1 chk("lu_rs_after", ADV);
        nxt(); hif.ID_EXmemRead = 1'b1; hif.ID_EXregisterRt = 5'd8; hif.IF_IDregisterRt = 5'd8;
        #1 chk("lu_rt", STALL);
        nxt(); #1 chk("lu_rt_after", ADV);

        // Register 0 never matches
        nxt(); hif.ID_EXmemRead = 1'b1; #1 chk("lu_r0", ADV);

        // Load then branch: RUN stall, BR_STALL stall, then the branch resolves taken
        nxt(); set_lu(5'd9); hif.IF_IDbranch = 1'b1; #1 chk("lb_stall1", STALL);
        nxt(); hif.IF_IDbranch = 1'b1; #1 chk("lb_stall2", STALL);
        nxt(); hif.IF_IDbranch = 1'b1; hif.branch_taken = 1'b1; #1 chk("lb_resolve", FLUSH);
        nxt(); #1 chk("lb_after", ADV);

        // Branch compare depending on a load in MEM: single stall
        nxt(); hif.IF_IDbranch = 1'b1; hif.EX_MEMmemRead = 1'b1;
        hif.EX_MEMregisterRd = 5'd5; hif.IF_IDregisterRt = 5'd5; #1 chk("bl_stall", STALL);
        nxt(); hif.IF_IDbranch = 1'b1; #1 chk("bl_after", ADV);
        nxt(); hif.IF_IDbranch = 1'b1; hif.EX_MEMmemRead = 1'b1; #1 chk("bl_r0", ADV);

        // Memory wait of 3 cycles; lu and branch_taken during the hold are ignored
        nxt(); hif.EX_MEMmemRead = 1'b1; hif.dmem_ready = 1'b0; #1 chk("mw_1", HOLD);
        nxt(); hif.EX_MEMmemRead = 1'b1; hif.dmem_ready = 1'b0; set_lu(5'd8);
        #1 chk("mw_2_lu", HOLD);
        nxt(); hif.EX_MEMmemRead = 1'b1; hif.dmem_ready = 1'b0; hif.branch_taken = 1'b1;
        #1 chk("mw_3_br", HOLD);
        nxt(); hif.EX_MEMmemRead = 1'b1; #1 chk("mw_release", ADV);
        nxt(); #1 chk("mw_after", ADV);

        // Taken branch alone, then with a concurrent load-use
        nxt(); hif.branch_taken = 1'b1; #1 chk("bt_flush", FLUSH);
        nxt(); #1 chk("bt_once", ADV);
        nxt(); hif.branch_taken = 1'b1; set_lu(5'd3); #1 chk("bt_lu_stall", STALL);
        nxt(); hif.branch_taken = 1'b1; #1 chk("bt_deferred", FLUSH);

        // BR_STALL entering a memory wait
        nxt(); set_lu(5'd9); hif.IF_IDbranch = 1'b1; #1 chk("brmw_stall", STALL);
        nxt(); hif.IF_IDbranch = 1'b1; hif.EX_MEMmemRead = 1'b1; hif.dmem_ready = 1'b0;
        #1 chk("brmw_hold", BHOLD);
        nxt(); hif.IF_IDbranch = 1'b1; hif.EX_MEMmemRead = 1'b1; hif.dmem_ready = 1'b0;
        #1 chk("brmw_wait", HOLD);
        nxt(); hif.IF_IDbranch = 1'b1; #1 chk("brmw_release", ADV);

        // Asynchronous reset while in BR_STALL
        nxt(); set_lu(5'd9); hif.IF_IDbranch = 1'b1; #1 chk("rst_lb1", STALL);
        nxt(); hif.IF_IDbranch = 1'b1; #1 chk("rst_in_brstall", STALL);
        #2 arst = 1'b1;
        #1 chk("rst_async", ADV);
        nxt(); hif.IF_IDbranch = 1'b1; arst = 1'b0; #1 chk("rst_release", ADV);
        nxt(); hif.IF_IDbranch = 1'b1; #1 chk("rst_no_stall", ADV);

`ifdef HDU_PERF_CNT_EN
        // 17 stall edges on a 4-bit counter wraps to 1
        nxt(); arst = 1'b1; #1 arst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            nxt(); hif.EX_MEMmemRead = 1'b1; hif.dmem_ready = 1'b0;
        end
        nxt(); #1;
        n_vec++;
        assert (stall_cycles === 4'd1) else begin
            n_err++;
            $error("FAIL cnt_wrap observed=%0d expected=1", stall_cycles);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
